// File: rtl/vector_list_player.sv
// Vector display-list player: steps through a list of JUMP/DRAW/END/NOP entries
// and hands each target point to a line drawer through a ready handshake.
module vector_list_player #(
    parameter int COORD_W = 12,
    parameter int DEPTH   = 64,
    parameter int ADDR_W  = 6
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     wr_en,
    input  logic [ADDR_W-1:0]        wr_addr,
    input  logic [2+2*COORD_W-1:0]   wr_data,
    input  logic                     enable,
    input  logic                     loop,
    input  logic                     ready,
    output logic [COORD_W-1:0]       x,
    output logic [COORD_W-1:0]       y,
    output logic                     draw,
    output logic                     jump,
    output logic                     busy,
    output logic                     frame_done,
    output logic [15:0]              frame_count
);

    localparam int                DW        = 2 + 2 * COORD_W;
    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(DEPTH - 1);
    localparam logic [ADDR_W:0]   DEPTH_LIM = (ADDR_W + 1)'(DEPTH);
    localparam logic [1:0]        OP_JUMP   = 2'b00;
    localparam logic [1:0]        OP_DRAW   = 2'b01;
    localparam logic [1:0]        OP_NOP    = 2'b11;

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_FETCH = 3'd1,
        S_ISSUE = 3'd2,
        S_HOLD  = 3'd3,
        S_DONE  = 3'd4
    } state_t;

    state_t              state_r;
    logic [DW-1:0]       mem_r [DEPTH];
    logic [DW-1:0]       rd_data_r;
    logic [ADDR_W-1:0]   rd_addr_r;
    logic                wr_ok_s;
    logic                last_s;
    logic [1:0]          op_s;
    logic [COORD_W-1:0]  ent_x_s;
    logic [COORD_W-1:0]  ent_y_s;

    assign wr_ok_s = wr_en && ({1'b0, wr_addr} < DEPTH_LIM);
    assign last_s  = (rd_addr_r == LAST_ADDR);
    assign op_s    = rd_data_r[DW-1 -: 2];
    assign ent_x_s = rd_data_r[2*COORD_W-1 -: COORD_W];
    assign ent_y_s = rd_data_r[COORD_W-1:0];

    // List memory: not reset, so a reset never loses the loaded picture; read-first on collision.
    always_ff @(posedge clk) begin
        if (wr_ok_s) begin
            mem_r[wr_addr] <= wr_data;
        end
        rd_data_r <= mem_r[rd_addr_r];
    end

    // Playback FSM; every output is registered and pulses default low each cycle.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r     <= S_IDLE;
            rd_addr_r   <= '0;
            x           <= '0;
            y           <= '0;
            draw        <= 1'b0;
            jump        <= 1'b0;
            busy        <= 1'b0;
            frame_done  <= 1'b0;
            frame_count <= 16'd0;
        end else begin
            draw       <= 1'b0;
            jump       <= 1'b0;
            frame_done <= 1'b0;
            case (state_r)
                S_IDLE: begin
                    if (enable) begin
                        rd_addr_r <= '0;
                        state_r   <= S_FETCH;
                        busy      <= 1'b1;
                    end else begin
                        busy      <= 1'b0;
                    end
                end
                S_FETCH: begin
                    state_r <= S_ISSUE;
                end
                S_ISSUE: begin
                    case (op_s)
                        OP_JUMP, OP_DRAW: begin
                            if (ready) begin
                                x       <= ent_x_s;
                                y       <= ent_y_s;
                                jump    <= (op_s == OP_JUMP);
                                draw    <= (op_s == OP_DRAW);
                                state_r <= S_HOLD;
                            end else begin
                                state_r <= S_ISSUE;
                            end
                        end
                        OP_NOP: begin
                            if (last_s) begin
                                state_r     <= S_DONE;
                                frame_done  <= 1'b1;
                                frame_count <= frame_count + 16'd1;
                            end else begin
                                rd_addr_r <= rd_addr_r + ADDR_W'(1);
                                state_r   <= S_FETCH;
                            end
                        end
                        default: begin
                            // END entry closes the pass without waiting on the drawer
                            state_r     <= S_DONE;
                            frame_done  <= 1'b1;
                            frame_count <= frame_count + 16'd1;
                        end
                    endcase
                end
                S_HOLD: begin
                    if (last_s) begin
                        state_r     <= S_DONE;
                        frame_done  <= 1'b1;
                        frame_count <= frame_count + 16'd1;
                    end else begin
                        rd_addr_r <= rd_addr_r + ADDR_W'(1);
                        state_r   <= S_FETCH;
                    end
                end
                S_DONE: begin
                    if (loop && enable) begin
                        rd_addr_r <= '0;
                        state_r   <= S_FETCH;
                    end else begin
                        state_r   <= S_IDLE;
                        busy      <= 1'b0;
                    end
                end
                default: begin
                    state_r <= S_IDLE;
                    busy    <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_vector_list_player.sv
// Self-checking bench for vector_list_player: a list-walking reference model predicts
// the command stream, frame pulses and (with ready high) the exact cycle of each event.
module tb_vector_list_player;

    localparam int CW  = 12;
    localparam int DEP = 16;
    localparam int AW  = 5;
    localparam int DW  = 2 + 2 * CW;

    logic            clk = 1'b0;
    logic            reset = 1'b1;
    logic            wr_en = 1'b0;
    logic [AW-1:0]   wr_addr = '0;
    logic [DW-1:0]   wr_data = '0;
    logic            enable = 1'b0;
    logic            loop = 1'b0;
    logic            ready = 1'b1;
    logic [CW-1:0]   x;
    logic [CW-1:0]   y;
    logic            draw;
    logic            jump;
    logic            busy;
    logic            frame_done;
    logic [15:0]     frame_count;

    typedef struct {
        int kind;   // 0 jump, 1 draw, 2 frame_done
        int xv;
        int yv;
        int cyc;
    } ev_t;

    ev_t           exp_q[$];
    ev_t           obs_q[$];
    ev_t           mon_e;
    logic [DW-1:0] mdl [DEP];
    int            total = 0;
    int            bad = 0;
    int            cyc = 0;
    int            viol = 0;
    bit            prev_dj = 1'b0;

    vector_list_player #(.COORD_W(CW), .DEPTH(DEP), .ADDR_W(AW)) dut (
        .clk(clk), .reset(reset), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
        .enable(enable), .loop(loop), .ready(ready), .x(x), .y(y), .draw(draw),
        .jump(jump), .busy(busy), .frame_done(frame_done), .frame_count(frame_count)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Output monitor: logs events and counts overlapping / back-to-back pulses
    always @(negedge clk) begin
        if (draw && jump) viol++;
        if ((draw || jump) && prev_dj) viol++;
        prev_dj = draw || jump;
        if (draw || jump) begin
            mon_e.kind = draw ? 1 : 0;
            mon_e.xv = int'(x);
            mon_e.yv = int'(y);
            mon_e.cyc = cyc;
            obs_q.push_back(mon_e);
        end
        if (frame_done) begin
            mon_e.kind = 2;
            mon_e.xv = 0;
            mon_e.yv = 0;
            mon_e.cyc = cyc;
            obs_q.push_back(mon_e);
        end
    end

    task automatic write_entry(input int addr, input logic [1:0] op, input int xv, input int yv);
        @(posedge clk); #1;
        wr_en = 1'b1;
        wr_addr = addr[AW-1:0];
        wr_data = {op, xv[CW-1:0], yv[CW-1:0]};
        if (addr < DEP) mdl[addr] = wr_data;
        @(posedge clk); #1;
        wr_en = 1'b0;
    endtask

    // Model of one pass: JUMP/DRAW cost 3 cycles each, NOP 2, END 3 to the frame pulse
    task automatic build_pass(inout int t);
        ev_t e;
        logic [1:0] op;
        for (int i = 0; i < DEP; i++) begin
            op = mdl[i][DW-1 -: 2];
            if (op == 2'b10) begin
                t += 3;
                e.kind = 2; e.xv = 0; e.yv = 0; e.cyc = t;
                exp_q.push_back(e);
                return;
            end else if (op == 2'b11) begin
                if (i == DEP - 1) begin
                    t += 3;
                    e.kind = 2; e.xv = 0; e.yv = 0; e.cyc = t;
                    exp_q.push_back(e);
                    return;
                end
                t += 2;
            end else begin
                t += 3;
                e.kind = (op == 2'b01) ? 1 : 0;
                e.xv = int'(mdl[i][2*CW-1 -: CW]);
                e.yv = int'(mdl[i][CW-1:0]);
                e.cyc = t;
                exp_q.push_back(e);
                if (i == DEP - 1) begin
                    t += 1;
                    e.kind = 2; e.xv = 0; e.yv = 0; e.cyc = t;
                    exp_q.push_back(e);
                    return;
                end
            end
        end
    endtask

    task automatic run_list(input string name, input int passes, input bit lp, input bit chk_cyc,
                            input bit rnd);
        int t;
        int guard;
        int seen;
        bit done_ok;
        logic [15:0] fc0;
        @(posedge clk); #1;
        exp_q.delete();
        obs_q.delete();
        viol = 0;
        fc0 = frame_count;
        t = cyc;
        for (int p = 0; p < passes; p++) build_pass(t);
        loop = lp;
        enable = 1'b1;
        ready = 1'b1;
        guard = 0;
        seen = 0;
        done_ok = 1'b0;
        while (!done_ok && guard < 4000) begin
            @(negedge clk);
            guard++;
            if (rnd) ready = 1'($urandom_range(0, 1));
            if (frame_done) seen++;
            if (busy && (!lp || seen >= passes)) enable = 1'b0;
            if (seen >= passes && !busy) done_ok = 1'b1;
        end
        ready = 1'b1;
        enable = 1'b0;
        total++;
        if (!done_ok) begin
            bad++;
            $display("FAIL %s timeout: frames seen=%0d want %0d", name, seen, passes);
        end
        total++;
        if (obs_q.size() != exp_q.size()) begin
            bad++;
            $display("FAIL %s event_count: got %0d want %0d", name, obs_q.size(), exp_q.size());
        end
        for (int i = 0; i < exp_q.size() && i < obs_q.size(); i++) begin
            total++;
            if (obs_q[i].kind != exp_q[i].kind || obs_q[i].xv != exp_q[i].xv ||
                obs_q[i].yv != exp_q[i].yv || (chk_cyc && obs_q[i].cyc != exp_q[i].cyc)) begin
                bad++;
                $display("FAIL %s ev%0d: got k=%0d x=%0d y=%0d c=%0d want k=%0d x=%0d y=%0d c=%0d",
                         name, i, obs_q[i].kind, obs_q[i].xv, obs_q[i].yv, obs_q[i].cyc,
                         exp_q[i].kind, exp_q[i].xv, exp_q[i].yv, exp_q[i].cyc);
            end
        end
        total++;
        if (frame_count !== fc0 + 16'(passes)) begin
            bad++;
            $display("FAIL %s frame_count: got %0d want %0d", name, frame_count, fc0 + 16'(passes));
        end
        total++;
        if (viol != 0) begin
            bad++;
            $display("FAIL %s pulse_spacing: got %0d violations want 0", name, viol);
        end
        total++;
        if (busy !== 1'b0) begin
            bad++;
            $display("FAIL %s busy_end: got %0b want 0", name, busy);
        end
    endtask

    task automatic check_reset_vals(input string name);
        total++;
        if (x !== '0 || y !== '0) begin
            bad++;
            $display("FAIL %s xy: got %0d,%0d want 0,0", name, x, y);
        end
        total++;
        if (draw !== 1'b0 || jump !== 1'b0 || frame_done !== 1'b0) begin
            bad++;
            $display("FAIL %s pulses: got d=%0b j=%0b fd=%0b want 0", name, draw, jump, frame_done);
        end
        total++;
        if (busy !== 1'b0) begin
            bad++;
            $display("FAIL %s busy: got %0b want 0", name, busy);
        end
        total++;
        if (frame_count !== 16'd0) begin
            bad++;
            $display("FAIL %s frame_count: got %0d want 0", name, frame_count);
        end
    endtask

    task automatic test_reset();
        repeat (2) @(posedge clk);
        #1 reset = 1'b0;
        @(negedge clk);
        check_reset_vals("reset");
    endtask

    task automatic test_basic();
        write_entry(0, 2'b00, 50, 10);
        write_entry(1, 2'b01, 0, 40);
        write_entry(2, 2'b01, 50, 50);
        write_entry(3, 2'b01, 0, 0);
        write_entry(4, 2'b10, 0, 0);
        write_entry(5, 2'b10, 0, 0);
        write_entry(16, 2'b10, 1, 1);
        write_entry(31, 2'b11, 2, 2);
        run_list("basic", 1, 1'b0, 1'b1, 1'b0);
    endtask

    task automatic test_loop();
        run_list("loop3", 3, 1'b1, 1'b1, 1'b0);
    endtask

    task automatic test_reset_mid();
        @(posedge clk); #1;
        loop = 1'b1;
        enable = 1'b1;
        ready = 1'b1;
        repeat (7) @(negedge clk);
        @(posedge clk); #1;
        reset = 1'b1;
        wr_en = 1'b1;
        wr_addr = 5'd4;
        wr_data = {2'b00, 12'd3, 12'd3};
        mdl[4] = wr_data;
        @(posedge clk); #1;
        reset = 1'b0;
        wr_en = 1'b0;
        enable = 1'b0;
        @(negedge clk);
        check_reset_vals("reset_mid");
        run_list("replay", 1, 1'b0, 1'b1, 1'b0);
    endtask

    task automatic test_ready_stall();
        int guard;
        write_entry(0, 2'b01, 7, 9);
        write_entry(1, 2'b10, 0, 0);
        @(posedge clk); #1;
        obs_q.delete();
        loop = 1'b0;
        ready = 1'b0;
        enable = 1'b1;
        @(posedge clk); #1;
        enable = 1'b0;
        repeat (21) @(posedge clk);
        #1;
        total++;
        if (obs_q.size() != 0 || x !== 12'd3 || y !== 12'd3) begin
            bad++;
            $display("FAIL stall_hold: got events=%0d x=%0d y=%0d want 0,3,3", obs_q.size(), x, y);
        end
        total++;
        if (busy !== 1'b1) begin
            bad++;
            $display("FAIL stall_busy: got %0b want 1", busy);
        end
        ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        total++;
        if (draw !== 1'b1 || jump !== 1'b0 || x !== 12'd7 || y !== 12'd9) begin
            bad++;
            $display("FAIL stall_release: got d=%0b j=%0b x=%0d y=%0d want 1,0,7,9", draw, jump, x, y);
        end
        guard = 0;
        while (busy && guard < 100) begin
            @(negedge clk);
            guard++;
        end
        total++;
        if (busy !== 1'b0) begin
            bad++;
            $display("FAIL stall_idle: got busy=%0b want 0", busy);
        end
    endtask

    task automatic test_full();
        for (int i = 0; i < DEP; i++) write_entry(i, 2'b01, int'($urandom_range(0, 4095)), i * 100);
        run_list("full", 1, 1'b0, 1'b1, 1'b0);
    endtask

    task automatic test_end_first();
        write_entry(0, 2'b10, 0, 0);
        run_list("end_first", 1, 1'b0, 1'b1, 1'b0);
    endtask

    task automatic test_random();
        int r;
        bit lp;
        for (int it = 0; it < 4; it++) begin
            for (int i = 0; i < DEP; i++) begin
                r = int'($urandom_range(0, 9));
                write_entry(i, (r < 4) ? 2'b00 : (r < 8) ? 2'b01 : (r == 8) ? 2'b11 : 2'b10,
                            int'($urandom_range(0, 4095)), int'($urandom_range(0, 4095)));
            end
            lp = 1'($urandom_range(0, 1));
            run_list($sformatf("random%0d", it), lp ? 2 : 1, lp, it[0], it[0] ? 1'b0 : 1'b1);
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_loop();
        test_reset_mid();
        test_ready_stall();
        test_full();
        test_end_first();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/vector_list_player.md
VECTOR_LIST_PLAYER -- requirements
Module: vector_list_player

Interface
REQ-001 Parameter COORD_W, default 12, SHALL set the coordinate width of x, y and the list entries.
REQ-002 Parameter DEPTH, default 64, SHALL set the number of display-list entries.
REQ-003 Parameter ADDR_W, default 6, SHALL set the list address width, with 2**ADDR_W >= DEPTH.
REQ-004 Port list, one per line:
  clk  in  1  sole clock, all logic on rising edge.
  reset  in  1  synchronous, active-high reset.
  wr_en  in  1  list write strobe.
  wr_addr  in  ADDR_W  list write address.
  wr_data  in  2+2*COORD_W  entry {op[1:0], x, y}.
  enable  in  1  play request (level).
  loop  in  1  1 = restart list after END, 0 = stop.
  ready  in  1  line drawer can accept a command.
  x  out  COORD_W  target x to line drawer.
  y  out  COORD_W  target y to line drawer.
  draw  out  1  one-cycle draw-to-(x,y) pulse.
  jump  out  1  one-cycle beam move-to-(x,y) pulse.
  busy  out  1  high in any state other than IDLE.
  frame_done  out  1  one-cycle pulse at end of each list pass.
  frame_count  out  16  completed passes, wraps 0xFFFF->0.

Function
REQ-005 Op encoding SHALL be 00=JUMP, 01=DRAW, 10=END, 11=NOP (skipped, no pulse).
REQ-006 List memory SHALL be DEPTH entries, write-synchronous on wr_en, registered read (1-cycle latency), read-first on same-address collision.
REQ-007 wr_addr >= DEPTH SHALL be ignored.
REQ-008 States SHALL be IDLE, FETCH, ISSUE, HOLD, DONE.
REQ-009 IDLE: when enable=1, rd_addr<=0 and go FETCH; else stay.
REQ-010 FETCH: present rd_addr to memory, go ISSUE next cycle.
REQ-011 ISSUE, op JUMP/DRAW: wait while ready=0; on ready=1 register x,y from entry, assert jump or draw for exactly the next cycle, go HOLD.
REQ-012 ISSUE, op NOP: no pulse, no wait on ready, advance address as REQ-013.
REQ-013 HOLD and NOP advance: if rd_addr==DEPTH-1 go DONE, else rd_addr+1 and go FETCH; HOLD ignores ready.
REQ-014 ISSUE, op END: no pulse, go DONE regardless of ready.
REQ-015 DONE: pulse frame_done one cycle, frame_count+1; if loop=1 and enable=1 go FETCH with rd_addr=0, else go IDLE.
REQ-016 enable SHALL only be sampled in IDLE and DONE; deassert mid-pass finishes the pass.
REQ-017 draw and jump SHALL never be high in the same cycle nor in consecutive cycles.
REQ-018 x, y SHALL hold last issued values between commands.
REQ-019 With ready held high, first pulse SHALL be visible 3 cycles after enable is sampled in IDLE; steady state 1 command per 3 cycles.
REQ-020 List writes during play SHALL be accepted; they affect an entry only if written before its FETCH.

Reset
REQ-021 reset=1 SHALL force state IDLE, rd_addr=0, x=0, y=0, draw=0, jump=0, busy=0, frame_done=0, frame_count=0, regardless of state, including mid-ISSUE.
REQ-022 reset SHALL NOT clear list memory; writes with reset=1 SHALL still be accepted.
REQ-023 Reset has priority over enable and wr_en-driven playback effects.

Verification
REQ-024 Load {JUMP(50,10),DRAW(0,40),DRAW(50,50),DRAW(0,0),END}, loop=0, ready=1, enable pulse -> jump@(50,10), draws @(0,40),(50,50),(0,0), one frame_done, frame_count=1, busy=0.
REQ-025 Same list, loop=1, enable=1 for 3 passes -> command sequence repeats, frame_count=3, no pulse gap beyond 3-cycle cadence except DONE cycle.
REQ-026 ready held low 20 cycles during ISSUE of DRAW(7,9) -> no pulse, x/y unchanged; ready high -> draw next cycle with x=7, y=9.
REQ-027 Entry0=END, loop=0 -> frame_done after 3 cycles, no draw/jump, frame_count=1.
REQ-028 DEPTH full of DRAW (no END), enable, ready=1 -> DEPTH draws, frame_done after entry DEPTH-1.
REQ-029 reset asserted one cycle mid-pass -> all outputs at reset values next cycle, memory contents intact, re-enable replays from entry 0.
